// File: rtl/fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : fifo_pkg                                                          |
// | Brief  : Shared types and helpers for the programmable synchronous FIFO.   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int PAR_MAX_W = 1024;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Narrower words are zero-extended by the caller; zeros do not change parity.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// +----------------------------------------------------------------------------+
// | Module : fifo_mem                                                          |
// | Brief  : DEPTH x WIDTH register array, one write port, async read port.    |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_mem #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_prog.sv
// +----------------------------------------------------------------------------+
// | Module : sync_fifo_prog                                                    |
// | Brief  : Single-clock FIFO with programmable thresholds, level, sticky     |
// |          error flags and optional FWFT read mode.                          |
// |          Define SYNC_FIFO_PARITY_EN to add per-entry parity + parity_err.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 16,
    parameter  int FWFT       = 0,
    localparam int CNT_W      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic [CNT_W-1:0]      level,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
`ifdef SYNC_FIFO_PARITY_EN
    output logic                  parity_err,
`endif
    input  logic                  clr_err
);

    localparam int         PTR_W = $clog2(DEPTH);
    localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
`ifdef SYNC_FIFO_PARITY_EN
    localparam int         PAR_W = 1;
`else
    localparam int         PAR_W = 0;
`endif
    localparam int         MEM_W = DATA_WIDTH + PAR_W;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [MEM_W-1:0] w_mem_wdata;
    logic [MEM_W-1:0] w_mem_rdata;

    assign full         = (level_q == CNT_W'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= af_thresh);
    assign almost_empty = (level_q <= ae_thresh);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign w_wr_acc = w_en && !full;
    assign w_rd_acc = r_en && !empty;

`ifdef SYNC_FIFO_PARITY_EN
    assign w_mem_wdata = {even_parity(PAR_MAX_W'(w_data)), w_data};
`else
    assign w_mem_wdata = w_data;
`endif

    fifo_mem #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (w_mem_wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_mem_rdata)
    );

    // Explicit wrap keeps non-power-of-two depths correct.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (w_wr_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (w_rd_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en && full) begin
            overflow_d = 1'b1;
        end
        if (r_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            assign r_data  = w_mem_rdata[DATA_WIDTH-1:0];
            assign r_valid = !empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
            logic                  rvalid_q, rvalid_d;

            always_comb begin
                rdata_d  = rdata_q;
                rvalid_d = w_rd_acc;
                if (w_rd_acc) begin
                    rdata_d = w_mem_rdata[DATA_WIDTH-1:0];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rdata_q  <= rdata_d;
                    rvalid_q <= rvalid_d;
                end
            end

            assign r_data  = rdata_q;
            assign r_valid = rvalid_q;
        end
    endgenerate

`ifdef SYNC_FIFO_PARITY_EN
    logic parity_err_q, parity_err_d;

    // Stored word plus its parity bit must XOR to zero when intact.
    always_comb begin
        parity_err_d = parity_err_q;
        if (clr_err) begin
            parity_err_d = 1'b0;
        end
        if (w_rd_acc && (^w_mem_rdata)) begin
            parity_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
// +----------------------------------------------------------------------------+
// | Module : tb_sync_fifo_prog                                                 |
// | Brief  : Directed self-checking bench; one FWFT=0 and one FWFT=1 instance. |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sync_fifo_prog;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] af, ae;

    logic          a_w_en, a_r_en, a_clr;
    logic [DW-1:0] a_w_data, a_r_data;
    logic          a_r_valid, a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
    logic [CW-1:0] a_level;

    logic          b_w_en, b_r_en, b_clr;
    logic [DW-1:0] b_w_data, b_r_data;
    logic          b_r_valid, b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
    logic [CW-1:0] b_level;

`ifdef SYNC_FIFO_PARITY_EN
    logic          a_perr, b_perr;
    logic [DW:0]   flip_v;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .w_en(a_w_en), .w_data(a_w_data),
        .r_en(a_r_en), .r_data(a_r_data), .r_valid(a_r_valid),
        .af_thresh(af), .ae_thresh(ae), .level(a_level), .full(a_full),
        .almost_full(a_af), .empty(a_empty), .almost_empty(a_ae),
        .overflow(a_ovf), .underflow(a_unf),
`ifdef SYNC_FIFO_PARITY_EN
        .parity_err(a_perr),
`endif
        .clr_err(a_clr)
    );

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .w_en(b_w_en), .w_data(b_w_data),
        .r_en(b_r_en), .r_data(b_r_data), .r_valid(b_r_valid),
        .af_thresh(af), .ae_thresh(ae), .level(b_level), .full(b_full),
        .almost_full(b_af), .empty(b_empty), .almost_empty(b_ae),
        .overflow(b_ovf), .underflow(b_unf),
`ifdef SYNC_FIFO_PARITY_EN
        .parity_err(b_perr),
`endif
        .clr_err(b_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; af = 5'd14; ae = 5'd2;
        a_w_en = 0; a_r_en = 0; a_clr = 0; a_w_data = '0;
        b_w_en = 0; b_r_en = 0; b_clr = 0; b_w_data = '0;
        tick(); tick();

        chk("rst_level", a_level, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_rvalid", a_r_valid, 0);
        chk("rst_rdata", a_r_data, 0);
        chk("rst_ae", a_ae, 1);
        chk("rst_af", a_af, 0);

        // Read while empty straight out of reset
        rst_n = 1'b1; a_r_en = 1; tick(); a_r_en = 0;
        chk("unf_set", a_unf, 1);
        chk("unf_level", a_level, 0);
        chk("unf_rvalid", a_r_valid, 0);
        a_clr = 1; tick(); a_clr = 0;
        chk("unf_clr", a_unf, 0);

        // Fill 0..15 and check threshold boundaries
        for (int i = 0; i < 16; i++) begin
            a_w_en = 1; a_w_data = i; tick();
            chk("fill_level", a_level, i + 1);
            if (i == 1)  chk("ae_at_2", a_ae, 1);
            if (i == 2)  chk("ae_at_3", a_ae, 0);
            if (i == 12) chk("af_at_13", a_af, 0);
            if (i == 13) chk("af_at_14", a_af, 1);
            if (i == 14) chk("full_at_15", a_full, 0);
        end
        chk("full_at_16", a_full, 1);
        a_w_data = 12345; tick(); a_w_en = 0;
        chk("ovf_set", a_ovf, 1);
        chk("ovf_level", a_level, 16);

        a_r_en = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("drain_valid", a_r_valid, 1);
            chk("drain_data", a_r_data, i);
        end
        a_r_en = 0; tick();
        chk("drain_idle_valid", a_r_valid, 0);
        chk("drain_hold_data", a_r_data, 15);
        chk("drain_empty", a_empty, 1);
        chk("drain_no_unf", a_unf, 0);
        a_clr = 1; tick(); a_clr = 0;
        chk("ovf_clr", a_ovf, 0);

        // Pointer wrap
        a_w_en = 1;
        for (int i = 0; i < 10; i++) begin a_w_data = 200 + i; tick(); end
        a_w_en = 0; a_r_en = 1;
        for (int i = 0; i < 10; i++) begin tick(); chk("wrap_pre", a_r_data, 200 + i); end
        a_r_en = 0; a_w_en = 1;
        for (int i = 0; i < 12; i++) begin a_w_data = 100 + i; tick(); end
        a_w_en = 0;
        chk("wrap_level12", a_level, 12);
        a_r_en = 1;
        for (int i = 0; i < 12; i++) begin tick(); chk("wrap_data", a_r_data, 100 + i); end
        a_r_en = 0;
        chk("wrap_level0", a_level, 0);

        // Simultaneous read/write at level 5
        a_w_en = 1;
        for (int i = 0; i < 5; i++) begin a_w_data = 300 + i; tick(); end
        chk("sim_level5", a_level, 5);
        a_r_en = 1;
        for (int i = 0; i < 4; i++) begin
            a_w_data = 305 + i; tick();
            chk("sim_data", a_r_data, 300 + i);
            chk("sim_level", a_level, 5);
        end
        a_w_en = 0;
        for (int i = 0; i < 5; i++) begin tick(); chk("sim_tail", a_r_data, 304 + i); end
        a_r_en = 0;
        chk("sim_empty", a_empty, 1);

        // Simultaneous at full: read wins, write dropped
        a_w_en = 1;
        for (int i = 0; i < 16; i++) begin a_w_data = 400 + i; tick(); end
        a_w_data = 999; a_r_en = 1; tick(); a_w_en = 0;
        chk("fullrw_data", a_r_data, 400);
        chk("fullrw_level", a_level, 15);
        chk("fullrw_ovf", a_ovf, 1);
        for (int i = 0; i < 7; i++) begin tick(); chk("fullrw_pop", a_r_data, 401 + i); end
        a_r_en = 0;
        chk("pre_rst_level", a_level, 8);

        // Reset with entries in flight
        rst_n = 0; tick(); rst_n = 1;
        chk("mid_rst_level", a_level, 0);
        chk("mid_rst_empty", a_empty, 1);
        chk("mid_rst_ovf", a_ovf, 0);
        chk("mid_rst_rvalid", a_r_valid, 0);
        tick(); tick();
        a_w_en = 1; a_w_data = 32'hA5; tick(); a_w_en = 0;
        a_r_en = 1; tick(); a_r_en = 0;
        chk("post_rst_valid", a_r_valid, 1);
        chk("post_rst_data", a_r_data, 32'hA5);

        // Simultaneous at empty: write wins, read dropped
        a_w_en = 1; a_r_en = 1; a_w_data = 32'h77; tick(); a_w_en = 0; a_r_en = 0;
        chk("emptyrw_level", a_level, 1);
        chk("emptyrw_unf", a_unf, 1);
        chk("emptyrw_valid", a_r_valid, 0);
        chk("emptyrw_hold", a_r_data, 32'hA5);
        a_r_en = 1; tick();
        chk("emptyrw_pop", a_r_data, 32'h77);
        a_clr = 1; tick(); a_clr = 0; a_r_en = 0;
        chk("err_beats_clr", a_unf, 1);
        a_clr = 1; tick(); a_clr = 0;
        chk("clr_alone", a_unf, 0);

        // Threshold extremes at full
        a_w_en = 1;
        for (int i = 0; i < 16; i++) begin a_w_data = i; tick(); end
        a_w_en = 0;
        ae = 5'd16; #1;
        chk("ae16_full", a_ae, 1);
        ae = 5'd15; #1;
        chk("ae15_full", a_ae, 0);
        rst_n = 0; tick(); rst_n = 1;
        af = 5'd0; #1;
        chk("af0_empty", a_af, 1);
        af = 5'd14; ae = 5'd2;

        // FWFT instance
        chk("fwft_idle_valid", b_r_valid, 0);
        b_w_en = 1; b_w_data = 32'hDEAD; tick(); b_w_en = 0;
        chk("fwft_valid", b_r_valid, 1);
        chk("fwft_data", b_r_data, 32'hDEAD);
        b_r_en = 1; tick(); b_r_en = 0;
        chk("fwft_pop_valid", b_r_valid, 0);
        b_w_en = 1; b_w_data = 32'h11; tick(); b_w_data = 32'h22; tick(); b_w_en = 0;
        chk("fwft_head1", b_r_data, 32'h11);
        b_r_en = 1; tick(); b_r_en = 0;
        chk("fwft_head2", b_r_data, 32'h22);
        chk("fwft_level", b_level, 1);

`ifdef SYNC_FIFO_PARITY_EN
        chk("std_perr_clean", a_perr, 0);
        chk("fwft_perr_clean", b_perr, 0);
        flip_v = u_fwft.w_mem_rdata ^ 33'h1;
        force u_fwft.w_mem_rdata = flip_v;
        b_r_en = 1; tick(); b_r_en = 0;
        release u_fwft.w_mem_rdata;
        chk("fwft_perr_set", b_perr, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
